// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants, derived totals and coordinate type
package vga_timing_pkg;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int SYNC_DLY      = 2;
    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    typedef logic [9:0] coord_t;
endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// sync_delay_line: DEPTH-stage shift register with configurable reset value; built only with VGA_SYNC_DELAY_EN
`ifdef VGA_SYNC_DELAY_EN
module sync_delay_line
    import vga_timing_pkg::*;
#(
    parameter int   DEPTH   = SYNC_DLY,
    parameter logic RST_VAL = 1'b1
) (
    input  logic vga_clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] sr;
    // shift d in at the bottom; the top stage is the delayed output
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) sr <= {DEPTH{RST_VAL}};
        else       sr <= (sr << 1) | DEPTH'(d);
    end
    assign q = sr[DEPTH-1];
endmodule
`endif

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA pixel/line counters with blank, hs/vs and start pulses; VGA_SYNC_DELAY_EN delays hs/vs by SYNC_DLY clocks
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start
);
    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam coord_t H_LAST = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS  = coord_t'(V_VISIBLE);
    localparam coord_t HS_BEG = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_BEG = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_range_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    coord_t hc_n, vc_n;
    logic   hs_r, vs_r;

    // next-state counters: pixel count wraps at end of line, line count wraps at end of frame
    always_comb begin
        hc_n = (DrawX == H_LAST) ? '0 : DrawX + 1'b1;
        vc_n = (DrawX != H_LAST) ? DrawY : (DrawY == V_LAST) ? '0 : DrawY + 1'b1;
    end

    // flags are decoded from the same next-state values as the counters, so they never skew
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            hs_r        <= 1'b1;
            vs_r        <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            DrawX       <= hc_n;
            DrawY       <= vc_n;
            blank       <= (hc_n < H_VIS) && (vc_n < V_VIS);
            hs_r        <= !((hc_n >= HS_BEG) && (hc_n < HS_END));
            vs_r        <= !((vc_n >= VS_BEG) && (vc_n < VS_END));
            line_start  <= hc_n == '0;
            frame_start <= (hc_n == '0) && (vc_n == '0);
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    sync_delay_line #(.DEPTH(SYNC_DLY), .RST_VAL(1'b1)) u_hs_dly (
        .vga_clk(vga_clk), .reset(reset), .d(hs_r), .q(hs)
    );
    sync_delay_line #(.DEPTH(SYNC_DLY), .RST_VAL(1'b1)) u_vs_dly (
        .vga_clk(vga_clk), .reset(reset), .d(vs_r), .q(vs)
    );
`else
    assign hs = hs_r;
    assign vs = vs_r;
`endif
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock. Drives the DrawX/DrawY/blank bus consumed by the sprite/palette renderers, and drives hs/vs to the DAC connector. It is the producer end of the DrawX/DrawY/blank interface; renderers only consume it.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_DLY, 2, extra hs/vs delay in clocks (used only under VGA_SYNC_DELAY_EN)

Ports:
vga_clk  input  1  pixel clock, 25 MHz
reset  input  1  asynchronous, active-high reset
DrawX  output  10  current horizontal count, 0..H_TOTAL-1
DrawY  output  10  current vertical count, 0..V_TOTAL-1
blank  output  1  1 = active video (DrawX<H_VISIBLE and DrawY<V_VISIBLE), 0 = blanking
hs  output  1  horizontal sync, active-low
vs  output  1  vertical sync, active-low
line_start  output  1  one-cycle pulse when DrawX==0
frame_start  output  1  one-cycle pulse when DrawX==0 and DrawY==0

Behaviour:
- H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525. All counts fit in 10 bits.
- Elaboration-time check: H_TOTAL<=1024 and V_TOTAL<=1024.
- Clock and reset: one clock, vga_clk. reset is asynchronous and active-high.
- Reset values: DrawX=0, DrawY=0, hs=1, vs=1, blank=0, line_start=0, frame_start=0.
- Horizontal counter:
  - hc increments every clock.
  - At hc==H_TOTAL-1 it wraps to 0, and vc increments.
  - At vc==V_TOTAL-1 together with the hc wrap, vc wraps to 0.
- DrawX=hc and DrawY=vc, both registered.
- hs, vs, blank, line_start and frame_start are all registered. They are decoded from the next-state counter values, so on every cycle they refer to the same (DrawX, DrawY) that is being output. There is no skew between the counters and the flags.
- hs=0 exactly when H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC, i.e. DrawX in 656..751.
- vs=0 exactly when V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC, i.e. DrawY in 490..491, for every DrawX on those lines.
- After reset is released:
  - First rising edge: DrawX=1, DrawY=0, blank=1.
  - The reset state (0,0) does not produce line_start or frame_start.
  - The first frame_start occurs when (0,0) is next reached, 420000 clocks later.
- Reset asserted mid-frame: all outputs go to their reset values immediately, with no clock required, and timing restarts from (0,0) as above.
- Renderer latency (ROM read plus RGB register) is the consumer's responsibility; with the macro disabled this block adds no compensation.

Optional Feature:
- Macro: VGA_SYNC_DELAY_EN.
- Defined:
  - hs and vs pass through a SYNC_DLY-stage shift register before the outputs, so they line up with RGB from pipelined renderers.
  - The shift register resets to all 1s.
  - blank, DrawX, DrawY, line_start and frame_start are not delayed.
- Not defined: hs and vs are aligned with DrawX/DrawY as specified above, and SYNC_DLY is ignored.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants;
  - the derived H_TOTAL and V_TOTAL;
  - a typedef for the 10-bit coordinate type.
- One natural sub-module: sync_delay_line.
  - Parameterised depth and reset value.
  - Instantiated twice (hs, vs), only under VGA_SYNC_DELAY_EN.

Test Plan:
- Reset check: hold reset for 5 clocks -> DrawX=0, DrawY=0, hs=1, vs=1, blank=0, no pulses. Release -> next edge gives DrawX=1, blank=1.
- Horizontal timing: run one line -> blank high for 640 consecutive clocks; hs low for exactly 96 clocks starting at DrawX=656; line period 800 clocks.
- Vertical timing and frame count: run 2 full frames -> vs low for 1600 clocks (lines 490..491); frame_start pulses exactly 420000 clocks apart; blank-high count per frame = 307200.
- Wrap-around: at DrawX=799, DrawY=524 -> next cycle DrawX=0, DrawY=0, with frame_start=1 and line_start=1 in that same cycle.
- Async reset mid-frame: assert reset at DrawX=300, DrawY=200 between clock edges -> outputs reach reset values before the next edge; timing restarts correctly after release.
- With VGA_SYNC_DELAY_EN and SYNC_DLY=2 -> hs falls when DrawX=658 and rises when DrawX=754; blank timing unchanged.
